spm_arbiter: RTL and testbench

Round-robin controller that shares one 32-bit signed serial-parallel `Multiplier` between `N_REQ` requesters. It accepts operand pairs over a valid/ready handshake and sequences the multiplier through clear, start and done. It returns the 64-bit product, tagged with the requester ID, over a response handshake. A watchdog aborts any operation whose `done` never arrives.

---
 rtl/spm_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/spm_arbiter.sv | 179 +++++++++++++++++
 tb/tb_spm_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier arbiter.
//   DATA_W  : operand width of the shared multiplier
//   PROD_W  : product width returned by the multiplier
//   WD_W    : width of the RUN-state watchdog counter
//   state_t : controller state encoding
package spm_pkg;

    localparam int DATA_W = 32;
    localparam int PROD_W = 64;
    localparam int WD_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans upward from last+1 (mod N_REQ) and grants the first valid requester.
//   req_valid : per-requester request lines
//   last      : index of the most recent grant
//   grant     : one-hot grant (all zero when nobody requests)
//   grant_idx : encoded index of the granted requester
//   grant_any : a grant exists this cycle
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Priority order is last+1, last+2, ... last+N_REQ (the latter being last itself).
        for (int off = 1; off <= N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_any && req_valid[i] && (i == (int'(last) + off) % N_REQ)) begin
                    grant[i]  = 1'b1;
                    grant_idx = ID_W'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spm_arbiter.sv
// Round-robin controller sharing one 32-bit signed serial-parallel multiplier
// between N_REQ requesters, with a watchdog on the multiplier's done.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester operand handshake (ready is a one-hot pulse)
//   req_mp/req_mc       : packed signed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_p/rsp_err: owner, product, watchdog abort flag
//   mul_rst/mul_start   : multiplier control
//   mul_mp/mul_mc       : operands held stable for the multiplier
//   mul_p/mul_done      : multiplier result and completion level
module spm_arbiter
    import spm_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ID_W    = 1,
    parameter int TIMEOUT = 40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [DATA_W*N_REQ-1:0]   req_mp,
    input  logic [DATA_W*N_REQ-1:0]   req_mc,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [PROD_W-1:0]         rsp_p,
    output logic                      rsp_err,
    output logic                      mul_rst,
    output logic                      mul_start,
    output logic [DATA_W-1:0]         mul_mp,
    output logic [DATA_W-1:0]         mul_mc,
    input  logic [PROD_W-1:0]         mul_p,
    input  logic                      mul_done
);

    state_t state_q, state_d;

    logic [N_REQ-1:0]          grant;
    logic [ID_W-1:0]           grant_idx;
    logic                      grant_any;
    logic [ID_W-1:0]           last_q;
    logic [WD_W-1:0]           wd_cnt_q;
    logic                      done_q;
    logic                      done_rise;
    logic                      accept;
    logic                      finish_ok;
    logic                      finish_err;

    logic signed [DATA_W-1:0]  sel_mp;
    logic signed [DATA_W-1:0]  sel_mc;
    logic signed [DATA_W-1:0]  mp_q;
    logic signed [DATA_W-1:0]  mc_q;
    logic signed [PROD_W-1:0]  p_q;
    logic [ID_W-1:0]           id_q;
    logic                      err_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req_valid (req_valid),
        .last      (last_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_mp = '0;
        sel_mc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_mp = req_mp[i*DATA_W +: DATA_W];
                sel_mc = req_mc[i*DATA_W +: DATA_W];
            end
        end
    end

    // Only a fresh rising edge counts; a done level left from an earlier
    // operation keeps done_q high and is therefore ignored.
    assign done_rise = mul_done && !done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        mul_start  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_any && !rst) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_d   = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                mul_start = 1'b1;
                // Completion wins over the watchdog when both land together.
                if (done_rise) begin
                    finish_ok = 1'b1;
                    state_d   = ST_RESP;
                end else if (wd_cnt_q == WD_W'(TIMEOUT)) begin
                    finish_err = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // System reset must also clear the multiplier, hence combinational.
    assign mul_rst = rst || (state_q == ST_CLR);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= ID_W'(N_REQ - 1);
            wd_cnt_q <= '0;
            done_q   <= 1'b0;
            mp_q     <= '0;
            mc_q     <= '0;
            id_q     <= '0;
            p_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            done_q <= mul_done;
            if (accept) begin
                mp_q   <= sel_mp;
                mc_q   <= sel_mc;
                id_q   <= grant_idx;
                last_q <= grant_idx;
            end
            // Counter is zero on the first RUN cycle and counts RUN cycles.
            if (state_q == ST_CLR) begin
                wd_cnt_q <= '0;
            end else if (state_q == ST_RUN) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            // Product is passed through untouched; sign handling lives in the multiplier.
            if (finish_ok) begin
                p_q   <= mul_p;
                err_q <= 1'b0;
            end else if (finish_err) begin
                p_q   <= '0;
                err_q <= 1'b1;
            end
        end
    end

    assign mul_mp  = mp_q;
    assign mul_mc  = mc_q;
    assign rsp_p   = p_q;
    assign rsp_id  = id_q;
    assign rsp_err = err_q;

endmodule

// File: tb/tb_spm_arbiter.sv
// Self-checking bench for spm_arbiter with a behavioural multiplier stub.
module tb_spm_arbiter;

    localparam int N_REQ   = 3;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [95:0] req_mp;
    logic [95:0] req_mc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_p;
    logic        rsp_err;
    logic        mul_rst;
    logic        mul_start;
    logic [31:0] mul_mp;
    logic [31:0] mul_mc;
    logic [63:0] mul_p;
    logic        mul_done;

    int errors = 0;
    int checks = 0;
    int model_last;

    logic [31:0] op_mp [3];
    logic [31:0] op_mc [3];

    // Multiplier stub: raises done (and keeps it) after stub_lat start cycles.
    int          stub_lat    = 1000;
    bit          stub_sticky = 1'b0;
    int          stub_cnt;
    logic [63:0] stub_p;
    logic        stub_done;

    assign mul_p    = stub_p;
    assign mul_done = stub_done;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_rst && !stub_sticky) begin
            stub_done <= 1'b0;
            stub_cnt  <= 0;
            stub_p    <= '0;
        end else if (mul_rst) begin
            stub_cnt <= 0;
        end else if (mul_start && !stub_done) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 == stub_lat) begin
                stub_done <= 1'b1;
                stub_p    <= 64'($signed(mul_mp) * $signed(mul_mc));
            end
        end
    end

    spm_arbiter #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mp    (req_mp),
        .req_mc    (req_mc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .rsp_err   (rsp_err),
        .mul_rst   (mul_rst),
        .mul_start (mul_start),
        .mul_mp    (mul_mp),
        .mul_mc    (mul_mc),
        .mul_p     (mul_p),
        .mul_done  (mul_done)
    );

    // ---------------- reference model ----------------
    function automatic int rr_pick(input int last, input logic [2:0] v);
        for (int k = 1; k <= N_REQ; k++) begin
            int j;
            j = (last + k) % N_REQ;
            if (((v >> j) & 3'b001) != 3'b000) return j;
        end
        return -1;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    // ---------------- drivers ----------------
    task automatic set_op(input int i, input logic [31:0] mp, input logic [31:0] mc);
        op_mp[i] = mp;
        op_mc[i] = mc;
        req_mp[i*32 +: 32] = mp;
        req_mc[i*32 +: 32] = mc;
    endtask

    task automatic wait_ready(output int idx, output logic [2:0] vec, output bit ok);
        ok  = 1'b0;
        idx = -1;
        vec = '0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (req_ready != 3'b000) begin
                ok  = 1'b1;
                vec = req_ready;
                for (int i = 0; i < 3; i++) if (req_ready[i]) idx = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            #1;
            if (rsp_valid) ok = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // One full transaction; cyc counts cycles from the CLR cycle to rsp_valid.
    task automatic run_txn(input logic [2:0] valids, input bit drop, input int lat, input int stall,
                           output int gidx, output logic [2:0] vec, output int cyc,
                           output logic [63:0] p, output logic [1:0] id, output logic err,
                           output bit ok);
        bit ok1, ok2;
        stub_lat  = lat;
        req_valid = valids;
        wait_ready(gidx, vec, ok1);
        if (drop) req_valid = valids & ~vec;
        wait_rsp(TIMEOUT + 10, cyc, ok2);
        p   = rsp_p;
        id  = rsp_id;
        err = rsp_err;
        ok  = ok1 && ok2;
        if (ok2) begin
            repeat (stall) @(negedge clk);
            release_rsp();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 3'b111;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mul_rst: got %b expected 1", mul_rst); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b expected 000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b expected 0", mul_start); end
        rst       = 1'b0;
        req_valid = 3'b000;
        #1;
        checks++; if (mul_rst !== 1'b0) begin errors++; $display("FAIL reset_mul_rst_release: got %b expected 0", mul_rst); end
        checks++; if (rsp_p !== 64'd0 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_regs: got p=%h id=%0d err=%b expected 0/0/0", rsp_p, rsp_id, rsp_err); end
        checks++; if (mul_mp !== 32'd0 || mul_mc !== 32'd0) begin
            errors++; $display("FAIL reset_operands: got mp=%h mc=%h expected 0/0", mul_mp, mul_mc); end
        model_last = N_REQ - 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int gidx, cyc, lat; logic [2:0] vec; logic [63:0] p; logic [1:0] id; logic err; bit ok;
        lat = $urandom_range(4, 30);
        set_op(0, 32'd7, 32'd9);
        run_txn(3'b001, 1'b1, lat, 0, gidx, vec, cyc, p, id, err, ok);
        model_last = 0;
        checks++; if (!ok) begin errors++; $display("FAIL single_handshake: got timeout expected response"); end
        checks++; if (vec !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected 001", vec); end
        checks++; if (p !== 64'd63 || id !== 2'd0 || err !== 1'b0) begin
            errors++; $display("FAIL single_rsp: got p=%0d id=%0d err=%b expected 63/0/0", p, id, err); end
        checks++; if (cyc != lat + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", cyc, lat + 2); end
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_negative();
        int gidx, cyc; logic [2:0] vec; logic [63:0] p; logic [1:0] id; logic err; bit ok;
        set_op(1, 32'hFFFF_FFFD, 32'd5);
        run_txn(3'b010, 1'b1, 12, 1, gidx, vec, cyc, p, id, err, ok);
        model_last = 1;
        checks++; if (!ok) begin errors++; $display("FAIL neg_handshake: got timeout expected response"); end
        checks++; if (p !== 64'hFFFF_FFFF_FFFF_FFF1 || id !== 2'd1 || err !== 1'b0) begin
            errors++; $display("FAIL neg_rsp: got p=%h id=%0d err=%b expected fffffffffffffff1/1/0", p, id, err); end
    endtask

    task automatic test_round_robin();
        int gidx, cyc, gexp; logic [2:0] vec; logic [63:0] p; logic [1:0] id; logic err; bit ok;
        int seq [4] = '{0, 1, 0, 1};
        set_op(0, 32'd2, 32'd3);
        set_op(1, 32'd4, 32'd5);
        for (int t = 0; t < 4; t++) begin
            gexp = rr_pick(model_last, 3'b011);
            run_txn(3'b011, 1'b0, $urandom_range(1, 35), 0, gidx, vec, cyc, p, id, err, ok);
            model_last = gexp;
            checks++; if (!ok || gidx != seq[t] || id !== 2'(seq[t])) begin
                errors++; $display("FAIL rr_grant[%0d]: got %0d/%0d expected %0d", t, gidx, id, seq[t]); end
            checks++; if (p !== ref_mul(op_mp[gexp], op_mc[gexp])) begin
                errors++; $display("FAIL rr_product[%0d]: got %0d expected %0d", t, p, ref_mul(op_mp[gexp], op_mc[gexp])); end
        end
        req_valid = 3'b000;
    endtask

    task automatic test_random();
        int gidx, cyc, gexp, lat; logic [2:0] vec, v; logic [63:0] p; logic [1:0] id; logic err; bit ok;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) set_op(i, 32'h8000_0000, $urandom);
                else set_op(i, $urandom, $urandom);
            end
            v    = 3'($urandom_range(1, 7));
            lat  = $urandom_range(1, TIMEOUT);
            gexp = rr_pick(model_last, v);
            run_txn(v, 1'b1, lat, $urandom_range(0, 3), gidx, vec, cyc, p, id, err, ok);
            model_last = gexp;
            checks++; if (!ok || gidx != gexp || vec !== 3'(1 << gexp)) begin
                errors++; $display("FAIL rand_grant[%0d]: got %0d (%b) expected %0d", t, gidx, vec, gexp); end
            checks++; if (p !== ref_mul(op_mp[gexp], op_mc[gexp]) || err !== 1'b0 || id !== 2'(gexp)) begin
                errors++; $display("FAIL rand_rsp[%0d]: got p=%h err=%b id=%0d expected %h/0/%0d", t, p, err, id,
                                   ref_mul(op_mp[gexp], op_mc[gexp]), gexp); end
            checks++; if (cyc != lat + 2) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, cyc, lat + 2); end
        end
        req_valid = 3'b000;
    endtask

    task automatic test_backpressure();
        int gidx, cyc, gexp; logic [2:0] vec; logic [63:0] p, pexp; logic [1:0] id; logic err; bit ok1, ok2;
        for (int i = 0; i < 3; i++) set_op(i, $urandom, $urandom);
        gexp      = rr_pick(model_last, 3'b111);
        pexp      = ref_mul(op_mp[gexp], op_mc[gexp]);
        stub_lat  = 10;
        req_valid = 3'b111;
        wait_ready(gidx, vec, ok1);
        wait_rsp(TIMEOUT + 10, cyc, ok2);
        model_last = gexp;
        checks++; if (!ok1 || !ok2 || gidx != gexp) begin
            errors++; $display("FAIL bp_handshake: got grant %0d ok=%b/%b expected %0d", gidx, ok1, ok2, gexp); end
        p = rsp_p; id = rsp_id; err = rsp_err;
        checks++; if (p !== pexp) begin errors++; $display("FAIL bp_product: got %h expected %h", p, pexp); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_p !== p || rsp_id !== id || rsp_err !== err) begin
                errors++; $display("FAIL bp_stable[%0d]: got v=%b p=%h id=%0d err=%b expected 1/%h/%0d/%b", c,
                                   rsp_valid, rsp_p, rsp_id, rsp_err, p, id, err); end
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 000", c, req_ready); end
        end
        release_rsp();
        req_valid = 3'b000;
    endtask

    task automatic test_watchdog();
        int gidx, cyc; logic [2:0] vec; logic [63:0] p; logic [1:0] id; logic err; bit ok;
        set_op(2, $urandom | 32'd1, $urandom | 32'd1);
        run_txn(3'b100, 1'b1, 1000, 0, gidx, vec, cyc, p, id, err, ok);
        model_last = 2;
        checks++; if (!ok || err !== 1'b1 || p !== 64'd0 || id !== 2'd2) begin
            errors++; $display("FAIL wd_abort: got ok=%b err=%b p=%h id=%0d expected 1/1/0/2", ok, err, p, id); end
        checks++; if (cyc != TIMEOUT + 2) begin errors++; $display("FAIL wd_latency: got %0d expected %0d", cyc, TIMEOUT + 2); end
        // done landing on the abort cycle is a success
        run_txn(3'b100, 1'b1, TIMEOUT, 0, gidx, vec, cyc, p, id, err, ok);
        checks++; if (!ok || err !== 1'b0 || p !== ref_mul(op_mp[2], op_mc[2]) || cyc != TIMEOUT + 2) begin
            errors++; $display("FAIL wd_edge_success: got err=%b p=%h cyc=%0d expected 0/%h/%0d", err, p, cyc,
                               ref_mul(op_mp[2], op_mc[2]), TIMEOUT + 2); end
        // one cycle later is too late
        run_txn(3'b100, 1'b1, TIMEOUT + 1, 0, gidx, vec, cyc, p, id, err, ok);
        checks++; if (!ok || err !== 1'b1 || p !== 64'd0 || cyc != TIMEOUT + 2) begin
            errors++; $display("FAIL wd_edge_abort: got err=%b p=%h cyc=%0d expected 1/0/%0d", err, p, cyc, TIMEOUT + 2); end
        set_op(0, 32'd11, 32'hFFFF_FFF9);
        run_txn(3'b001, 1'b1, 8, 0, gidx, vec, cyc, p, id, err, ok);
        model_last = 0;
        checks++; if (!ok || err !== 1'b0 || p !== 64'hFFFF_FFFF_FFFF_FFB3 || id !== 2'd0) begin
            errors++; $display("FAIL wd_recover: got err=%b p=%h id=%0d expected 0/ffffffffffffffb3/0", err, p, id); end
    endtask

    task automatic test_stale_done();
        int gidx, cyc; logic [2:0] vec; logic [63:0] p; logic [1:0] id; logic err; bit ok;
        set_op(0, 32'd6, 32'd7);
        set_op(1, 32'd8, 32'd9);
        run_txn(3'b001, 1'b1, 5, 0, gidx, vec, cyc, p, id, err, ok);
        model_last = 0;
        stub_sticky = 1'b1;
        run_txn(3'b010, 1'b1, 5, 0, gidx, vec, cyc, p, id, err, ok);
        model_last = 1;
        checks++; if (!ok || err !== 1'b1 || p !== 64'd0 || cyc != TIMEOUT + 2) begin
            errors++; $display("FAIL stale_done: got err=%b p=%h cyc=%0d expected 1/0/%0d", err, p, cyc, TIMEOUT + 2); end
        stub_sticky = 1'b0;
        run_txn(3'b010, 1'b1, 5, 0, gidx, vec, cyc, p, id, err, ok);
        checks++; if (!ok || err !== 1'b0 || p !== 64'd72) begin
            errors++; $display("FAIL stale_recover: got err=%b p=%0d expected 0/72", err, p); end
    endtask

    task automatic test_reset_mid();
        int gidx, cyc; logic [2:0] vec; logic [63:0] p; logic [1:0] id; logic err; bit ok, seen;
        set_op(0, 32'h1234_5678, 32'h0000_0101);
        stub_lat  = 1000;
        req_valid = 3'b001;
        wait_ready(gidx, vec, ok);
        req_valid = 3'b000;
        checks++; if (!ok || gidx != 0) begin errors++; $display("FAIL rstmid_grant: got %0d expected 0", gidx); end
        repeat (10) @(negedge clk);
        #1;
        checks++; if (mul_start !== 1'b1 || mul_mp !== 32'h1234_5678) begin
            errors++; $display("FAIL rstmid_run: got start=%b mp=%h expected 1/12345678", mul_start, mul_mp); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_last = N_REQ - 1;
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_p !== 64'd0 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL rstmid_rsp: got v=%b err=%b p=%h id=%0d expected 0/0/0/0", rsp_valid, rsp_err, rsp_p, rsp_id); end
        checks++; if (mul_start !== 1'b0 || mul_rst !== 1'b0 || mul_mp !== 32'd0 || mul_mc !== 32'd0) begin
            errors++; $display("FAIL rstmid_mul: got start=%b rst=%b mp=%h mc=%h expected 0/0/0/0", mul_start, mul_rst, mul_mp, mul_mc); end
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_no_rsp: got response expected none"); end
        set_op(0, 32'd3, 32'd4);
        set_op(1, 32'd5, 32'd6);
        run_txn(3'b011, 1'b1, 6, 0, gidx, vec, cyc, p, id, err, ok);
        model_last = 0;
        checks++; if (!ok || gidx != 0 || p !== 64'd12 || err !== 1'b0) begin
            errors++; $display("FAIL rstmid_next: got grant=%0d p=%0d err=%b expected 0/12/0", gidx, p, err); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 3'b000;
        rsp_ready = 1'b0;
        req_mp    = '0;
        req_mc    = '0;
        for (int i = 0; i < 3; i++) begin
            op_mp[i] = '0;
            op_mc[i] = '0;
        end
        test_reset();
        test_single();
        test_negative();
        test_round_robin();
        test_random();
        test_backpressure();
        test_watchdog();
        test_stale_done();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
